// File: rtl/ckp_wheel_generator_pkg.sv
// Shared wheel geometry, period limits and FSM encoding for the CKP wheel generator.
// Other EFI blocks take the same wheel geometry values, so the receiver and the transmitter stay consistent.
package ckp_wheel_generator_pkg;

    localparam int CFG_NUM_TEETH           = 60;
    localparam int CFG_NUM_LOST_TEETH      = 2;
    localparam int CFG_CYCLE_COUNTER_WIDTH = 16;
    localparam int CFG_CKP_PERIOD_WIDTH    = 24;
    localparam int CFG_CKP_DEFAULT_PERIOD  = 1000;
    localparam int CFG_CKP_MIN_PERIOD      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } ckp_state_e;

endpackage

// File: rtl/ckp_wheel_generator_tooth_slot_timer.sv
// Tooth-slot timebase: shadow/active period registers, phase counter and slot boundary detect.
// high_phase is computed for the upcoming cycle so the top can register ckp without extra latency.
module tooth_slot_timer
    import ckp_wheel_generator_pkg::*;
#(
    parameter int PERIOD_WIDTH   = CFG_CKP_PERIOD_WIDTH,
    parameter int DEFAULT_PERIOD = CFG_CKP_DEFAULT_PERIOD,
    parameter int MIN_PERIOD     = CFG_CKP_MIN_PERIOD
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    start,
    input  logic                    period_load,
    input  logic [PERIOD_WIDTH-1:0] tooth_period,
    output logic                    boundary,
    output logic                    high_phase,
    output logic                    load_reject
);

    localparam logic [PERIOD_WIDTH-1:0] ONE      = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PER_INIT = PERIOD_WIDTH'(DEFAULT_PERIOD);

    logic [PERIOD_WIDTH-1:0] shadow_period;
    logic [PERIOD_WIDTH-1:0] active_period;
    logic [PERIOD_WIDTH-1:0] phase;
    logic [PERIOD_WIDTH-1:0] shadow_next;
    logic [PERIOD_WIDTH-1:0] active_next;
    logic [PERIOD_WIDTH-1:0] phase_next;
    logic                    load_ok;

    function automatic logic period_legal(input logic [PERIOD_WIDTH-1:0] p);
        return p >= PERIOD_WIDTH'(MIN_PERIOD);
    endfunction

    assign load_ok     = period_load && period_legal(tooth_period);
    assign load_reject = period_load && !period_legal(tooth_period);

    always_comb begin
        shadow_next = load_ok ? tooth_period : shadow_period;
        boundary    = run && (phase == active_period - ONE);
        active_next = active_period;
        phase_next  = '0;
        // A start is treated as a boundary so the first slot picks up the latest shadow value.
        if (start || boundary) begin
            active_next = shadow_next;
        end
        if (run && !boundary) begin
            phase_next = phase + ONE;
        end
        high_phase = phase_next < (active_next >> 1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_period <= PER_INIT;
            active_period <= PER_INIT;
            phase         <= '0;
        end else begin
            shadow_period <= shadow_next;
            active_period <= active_next;
            phase         <= phase_next;
        end
    end

endmodule

// File: rtl/ckp_wheel_generator.sv
// Crank-position wheel transmitter: toothed wheel with missing teeth, programmable slot period,
// tooth index and revolution count reported for comparison against the EFI receiver.
module ckp_wheel_generator
    import ckp_wheel_generator_pkg::*;
#(
    parameter int NUM_TEETH           = CFG_NUM_TEETH,
    parameter int NUM_LOST_TEETH      = CFG_NUM_LOST_TEETH,
    parameter int CYCLE_COUNTER_WIDTH = CFG_CYCLE_COUNTER_WIDTH,
    parameter int PERIOD_WIDTH        = CFG_CKP_PERIOD_WIDTH,
    parameter int DEFAULT_PERIOD      = CFG_CKP_DEFAULT_PERIOD,
    parameter int MIN_PERIOD          = CFG_CKP_MIN_PERIOD,
    localparam int TW                 = $clog2(NUM_TEETH)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           on,
    input  logic                           period_load,
    input  logic [PERIOD_WIDTH-1:0]        tooth_period,
    output logic                           ckp,
    output logic [TW-1:0]                  tooth_index,
    output logic [CYCLE_COUNTER_WIDTH-1:0] rev_counter,
    output logic                           sync_pulse,
    output logic                           busy,
    output logic                           period_err
);

    localparam logic [TW-1:0] LAST_TOOTH = TW'(NUM_TEETH - 1);
    localparam logic [TW-1:0] TEETH_ON   = TW'(NUM_TEETH - NUM_LOST_TEETH);
    localparam logic [TW-1:0] TOOTH_ONE  = TW'(1);
    localparam logic [CYCLE_COUNTER_WIDTH-1:0] REV_ONE = CYCLE_COUNTER_WIDTH'(1);

    ckp_state_e                     state;
    ckp_state_e                     state_next;
    logic [TW-1:0]                  tooth_next;
    logic [CYCLE_COUNTER_WIDTH-1:0] rev_next;
    logic                           sync_next;
    logic                           busy_next;
    logic                           ckp_next;
    logic                           boundary;
    logic                           high_phase;
    logic                           load_reject;
    logic                           run;
    logic                           start;

    assign run   = (state != IDLE);
    assign start = (state == IDLE) && on;

    tooth_slot_timer #(
        .PERIOD_WIDTH   (PERIOD_WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD     (MIN_PERIOD)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .start        (start),
        .period_load  (period_load),
        .tooth_period (tooth_period),
        .boundary     (boundary),
        .high_phase   (high_phase),
        .load_reject  (load_reject)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tooth_next = tooth_index;
        rev_next   = rev_counter;
        sync_next  = 1'b0;
        case (state)
            IDLE: begin
                tooth_next = '0;
                if (on) begin
                    state_next = RUN;
                    sync_next  = 1'b1;
                end
            end
            RUN: begin
                if (!on) state_next = STOP;
            end
            STOP: begin
                // Returning to RUN before the boundary leaves the waveform untouched.
                if (on) state_next = RUN;
                else if (boundary) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (run && boundary) begin
            if (tooth_index == LAST_TOOTH) begin
                tooth_next = '0;
                rev_next   = rev_counter + REV_ONE;
            end else begin
                tooth_next = tooth_index + TOOTH_ONE;
            end
            if (state_next == IDLE) tooth_next = '0;
            sync_next = (state_next != IDLE) && (tooth_index == LAST_TOOTH);
        end

        busy_next = (state_next != IDLE);
        ckp_next  = busy_next && high_phase && (tooth_next < TEETH_ON);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ckp         <= 1'b0;
            tooth_index <= '0;
            rev_counter <= '0;
            sync_pulse  <= 1'b0;
            busy        <= 1'b0;
            period_err  <= 1'b0;
        end else begin
            ckp         <= ckp_next;
            tooth_index <= tooth_next;
            rev_counter <= rev_next;
            sync_pulse  <= sync_next;
            busy        <= busy_next;
            period_err  <= load_reject;
        end
    end

endmodule

// File: tb/tb_ckp_wheel_generator.sv
// Directed bench for the CKP wheel generator: 60-2 wheel, default period 1000.
module tb_ckp_wheel_generator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        on;
    logic        period_load;
    logic [23:0] tooth_period;
    logic        ckp;
    logic [5:0]  tooth_index;
    logic [15:0] rev_counter;
    logic        sync_pulse;
    logic        busy;
    logic        period_err;

    int total = 0;
    int bad   = 0;

    ckp_wheel_generator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .on           (on),
        .period_load  (period_load),
        .tooth_period (tooth_period),
        .ckp          (ckp),
        .tooth_index  (tooth_index),
        .rev_counter  (rev_counter),
        .sync_pulse   (sync_pulse),
        .busy         (busy),
        .period_err   (period_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_level(input logic lvl, input int budget, output int n);
        n = 0;
        while (ckp === lvl && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_tooth(input int idx, input int budget, output logic hit);
        int n = 0;
        while (int'(tooth_index) != idx && n < budget) begin
            n++;
            tick();
        end
        hit = (int'(tooth_index) == idx);
    endtask

    task automatic count_in_tooth(input int idx, input int budget, output int n);
        n = 0;
        while (int'(tooth_index) == idx && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_sync(input int budget, output int n);
        n = 0;
        while (sync_pulse !== 1'b1 && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic count_busy(input int budget, output int n);
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic load(input logic [23:0] p);
        period_load  = 1'b1;
        tooth_period = p;
        tick();
        period_load  = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic hit;
        reset_n      = 1'b0;
        on           = 1'b0;
        period_load  = 1'b0;
        tooth_period = '0;
        repeat (3) tick();
        check("rst_ckp", 32'(ckp), 0);
        check("rst_tooth", 32'(tooth_index), 0);
        check("rst_rev", 32'(rev_counter), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sync", 32'(sync_pulse), 0);
        check("rst_perr", 32'(period_err), 0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("idle_ckp", 32'(ckp), 0);

        // Start at the default period: ckp one cycle after on, 500/500 pulses.
        on = 1'b1;
        tick();
        check("start_ckp", 32'(ckp), 1);
        check("start_sync", 32'(sync_pulse), 1);
        check("start_busy", 32'(busy), 1);
        check("start_tooth", 32'(tooth_index), 0);
        run_level(1'b1, 2000, n);
        check("def_high", 32'(n), 500);
        run_level(1'b0, 2000, n);
        check("def_low", 32'(n), 500);
        check("tooth1", 32'(tooth_index), 1);
        check("sync_off", 32'(sync_pulse), 0);

        // Mid-slot load in slot 10 only takes effect from slot 11.
        wait_tooth(10, 12000, hit);
        check("reach_t10", 32'(hit), 1);
        repeat (500) tick();
        load(24'd100);
        count_in_tooth(10, 2000, n);
        check("slot10_rest", 32'(n), 499);
        run_level(1'b1, 2000, n);
        check("p100_high", 32'(n), 50);
        run_level(1'b0, 2000, n);
        check("p100_low", 32'(n), 50);
        check("tooth12", 32'(tooth_index), 12);

        wait_sync(10000, n);
        check("to_sync", 32'(n), 4800);
        check("rev1", 32'(rev_counter), 1);
        check("sync_ckp", 32'(ckp), 1);
        tick();
        wait_sync(10000, n);
        check("sync_interval", 32'(n), 5999);
        check("rev2", 32'(rev_counter), 2);

        // Missing-tooth gap: last pulse low half plus two empty slots.
        wait_tooth(57, 7000, hit);
        check("reach_t57", 32'(hit), 1);
        run_level(1'b1, 1000, n);
        check("t57_high", 32'(n), 50);
        run_level(1'b0, 1000, n);
        check("gap_low", 32'(n), 250);
        check("gap_sync", 32'(sync_pulse), 1);
        check("rev3", 32'(rev_counter), 3);

        // Illegal period is rejected with a one-cycle error pulse.
        repeat (10) tick();
        load(24'd3);
        check("perr_pulse", 32'(period_err), 1);
        tick();
        check("perr_clear", 32'(period_err), 0);
        count_in_tooth(0, 1000, n);
        run_level(1'b1, 1000, n);
        check("after_err_high", 32'(n), 50);
        run_level(1'b0, 1000, n);
        check("after_err_low", 32'(n), 50);

        // Odd period: extra cycle goes low.
        load(24'd7);
        count_in_tooth(2, 1000, n);
        run_level(1'b1, 100, n);
        check("p7_high_a", 32'(n), 3);
        run_level(1'b0, 100, n);
        check("p7_low_a", 32'(n), 4);
        run_level(1'b1, 100, n);
        check("p7_high_b", 32'(n), 3);
        run_level(1'b0, 100, n);
        check("p7_low_b", 32'(n), 4);

        // Stop back to IDLE, then restart at 400 and stop at phase 200 of slot 5.
        load(24'd400);
        on = 1'b0;
        count_busy(2000, n);
        check("stop1_idle", 32'(busy), 0);
        on = 1'b1;
        tick();
        check("run2_sync", 32'(sync_pulse), 1);
        wait_tooth(5, 5000, hit);
        check("reach_t5", 32'(hit), 1);
        repeat (200) tick();
        on = 1'b0;
        tick();
        check("stop_busy", 32'(busy), 1);
        count_busy(2000, n);
        check("stop_len", 32'(n), 199);
        check("stop_ckp", 32'(ckp), 0);
        check("stop_tooth", 32'(tooth_index), 0);
        check("stop_rev", 32'(rev_counter), 3);

        // Brief off inside a slot leaves the waveform intact.
        on = 1'b1;
        tick();
        check("run3_ckp", 32'(ckp), 1);
        repeat (100) tick();
        on = 1'b0;
        tick();
        check("blip_busy", 32'(busy), 1);
        check("blip_ckp", 32'(ckp), 1);
        on = 1'b1;
        tick();
        run_level(1'b1, 1000, n);
        check("blip_high", 32'(n), 98);
        run_level(1'b0, 1000, n);
        check("blip_low", 32'(n), 200);
        check("blip_tooth", 32'(tooth_index), 1);

        // Asynchronous reset inside the slot-59 gap.
        load(24'd10);
        wait_tooth(59, 5000, hit);
        check("reach_t59", 32'(hit), 1);
        repeat (3) tick();
        check("gap59_ckp", 32'(ckp), 0);
        reset_n = 1'b0;
        #1;
        check("arst_tooth", 32'(tooth_index), 0);
        check("arst_rev", 32'(rev_counter), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ckp", 32'(ckp), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_run_sync", 32'(sync_pulse), 1);
        check("rst_run_ckp", 32'(ckp), 1);
        check("rst_run_tooth", 32'(tooth_index), 0);
        run_level(1'b1, 2000, n);
        check("rst_def_high", 32'(n), 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
